dmem_lsu: RTL and testbench

- Parametrised data-memory subsystem that replaces the plain word-wide dmem.
- Adds RISC-V byte/half/word loads and stores, including sign or zero extension for loads.
- Adds configurable read latency, a valid/ready request handshake, and a single-cycle response pulse.
- Flags misaligned accesses, out-of-range accesses and reserved sizes with an error response.
- Sits between the core's MEM stage and the backing storage; one request is outstanding at a time.

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_lsu_if.sv | 27 ++
 rtl/dmem_bank.sv | 50 +++++
 rtl/dmem_lsu.sv | 119 +++++++++++
 tb/tb_dmem_lsu.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory load/store unit.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte-lane enables for a store of the given size at the given lane.
  function automatic logic [3:0] be_from_size(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SIZE_B:  be = 4'b0001 << lane;
      SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Align the addressed lane to bit 0, mask to size, then sign/zero extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                              input size_e size, input logic is_unsigned);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {lane, 3'b000};
    case (size)
      SIZE_B:  res = is_unsigned ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SIZE_H:  res = is_unsigned ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SIZE_W:  res = sh;
      default: res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bus between the MEM stage (master) and the LSU (slave).
// Handshake: a request transfers on the rising edge where req_valid && req_ready;
// the master holds all req_* stable while req_valid is high and req_ready is low.
// rsp_valid is a single-cycle pulse; rsp_err is meaningful only with it.
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_bank.sv
// Word-wide storage with byte-enable writes, synchronous read and an
// optional output delay line that stretches read latency to READ_LAT.
module dmem_bank #(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1,
  localparam int IDXW       = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [3:0]      i_be,
  input  logic            i_re,
  input  logic [IDXW-1:0] i_idx,
  input  logic [31:0]     i_wdata,
  output logic [31:0]     o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rd;

  // Storage write per enabled lane; read register only updates on a read so
  // the delayed output stays stable between loads. Contents are not reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    if (i_re) r_rd <= r_mem[i_idx];
  end

  if (READ_LAT == 1) begin : g_nodly
    assign o_rdata = r_rd;
  end else begin : g_dly
    logic [31:0] r_dly [READ_LAT-1];

    // Free-running delay line behind the read register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < READ_LAT-1; i++) r_dly[i] <= 32'h0;
      end else begin
        r_dly[0] <= r_rd;
        for (int i = 1; i < READ_LAT-1; i++) r_dly[i] <= r_dly[i-1];
      end
    end

    assign o_rdata = r_dly[READ_LAT-2];
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: request checks, IDLE/WAIT/RESP sequencing, load extension.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  dmem_lsu_if.slave   bus,
  output state_e      o_state
);

  localparam int          IDXW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(4 * DEPTH_WORDS);

  state_e      r_state, w_state_nxt;
  logic [1:0]  r_cnt, w_cnt_nxt;
  logic        r_err, r_ld_ok, r_uns;
  logic [1:0]  r_lane;
  size_e       r_size;
  logic [31:0] r_hold;

  logic            w_accept, w_misalign, w_oor, w_err;
  size_e           w_size;
  logic [1:0]      w_lane;
  logic [31:0]     w_off, w_wdata_sh, w_bank_rdata, w_live;
  logic [IDXW-1:0] w_idx;
  logic [3:0]      w_be;

  assign w_accept   = bus.req_valid && (r_state == IDLE);
  assign w_size     = size_e'(bus.req_size);
  assign w_lane     = bus.req_addr[1:0];
  assign w_off      = bus.req_addr - BASE_ADDR;
  assign w_idx      = w_off[IDXW+1:2];
  assign w_misalign = ((w_size == SIZE_H) && w_lane[0]) || ((w_size == SIZE_W) && (w_lane != 2'b00));
  assign w_oor      = (bus.req_addr < BASE_ADDR) || ({1'b0, w_off} >= SPAN);
  assign w_err      = w_misalign || w_oor || (w_size == SIZE_RSV);
  assign w_be       = be_from_size(w_size, w_lane);
  assign w_wdata_sh = bus.req_wdata << {w_lane, 3'b000};

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS), .READ_LAT(READ_LAT)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_accept && bus.req_we && !w_err),
    .i_be    (w_be),
    .i_re    (w_accept && !bus.req_we && !w_err),
    .i_idx   (w_idx),
    .i_wdata (w_wdata_sh),
    .o_rdata (w_bank_rdata)
  );

  // State and latency counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: stores and errors respond next cycle, loads after READ_LAT.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (bus.req_we || w_err || (READ_LAT == 1)) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 2'(READ_LAT - 1);
          end
        end
      end
      WAIT: begin
        if (r_cnt == 2'd1) w_state_nxt = RESP;
        else               w_cnt_nxt   = r_cnt - 2'd1;
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture request attributes at accept; latch the response when leaving RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err   <= 1'b0;
      r_ld_ok <= 1'b0;
      r_uns   <= 1'b0;
      r_lane  <= 2'b00;
      r_size  <= SIZE_B;
      r_hold  <= 32'h0;
    end else begin
      if (w_accept) begin
        r_err   <= w_err;
        r_ld_ok <= !bus.req_we && !w_err;
        r_uns   <= bus.req_unsigned;
        r_lane  <= w_lane;
        r_size  <= w_size;
      end
      if (r_state == RESP) r_hold <= w_live;
    end
  end

  assign w_live = r_ld_ok ? load_extend(w_bank_rdata, r_lane, r_size, r_uns) : 32'h0;

  assign bus.req_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_rdata = (r_state == RESP) ? w_live : r_hold;
  assign bus.rsp_err   = r_err;
  assign o_state       = r_state;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu with READ_LAT=3: vector table, back-to-back loads,
// and reset during an in-flight load.
module tb_dmem_lsu;
  import dmem_pkg::*;

  localparam int LAT   = 3;
  localparam int DEPTH = 1024;

  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;

  always #5 clk = ~clk;

  dmem_lsu_if bus();

  dmem_lsu #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .READ_LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          rsp_cnt = 0;
  int unsigned cyc = 0;
  // {rdata[67:36], err[35], latency[34:32], accept cycle[31:0]}
  logic [67:0] exp_q[$];
  vec_t        vecs[20];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [67:0] e;
    if (bus.rsp_valid === 1'b1) begin
      rsp_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rdata %h err %b, expected no response", bus.rsp_rdata, bus.rsp_err);
      end else begin
        e = exp_q.pop_front();
        check("rsp_rdata", bus.rsp_rdata, e[67:36]);
        check("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e[35]});
        check("rsp_latency", cyc - e[31:0], {29'h0, e[34:32]});
      end
    end
  end

  // Drive one request and wait for its accept edge; optionally record an expectation.
  task automatic issue(input vec_t v, input bit keep_valid, input bit expect_rsp);
    int t = 0;
    int lat;
    @(negedge clk);
    bus.req_we       = v.we;
    bus.req_size     = v.size;
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_valid    = 1'b1;
    while (bus.req_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got req_ready %b, expected 1", bus.req_ready);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    lat = (!v.we && !v.exp_err) ? LAT : 1;
    if (expect_rsp) exp_q.push_back({v.exp_rdata, v.exp_err, 3'(lat), cyc});
    #1;
    if (!keep_valid) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_cnt;
    vecs[0]  = mk(1, 2'b10, 0, 32'd0,    32'hADCEAFCD, 32'h0,        0);
    vecs[1]  = mk(0, 2'b10, 0, 32'd0,    32'h0,        32'hADCEAFCD, 0);
    vecs[2]  = mk(1, 2'b10, 0, 32'd4,    32'hDECFECDA, 32'h0,        0);
    vecs[3]  = mk(1, 2'b00, 0, 32'd5,    32'h00000080, 32'h0,        0);
    vecs[4]  = mk(0, 2'b10, 0, 32'd4,    32'h0,        32'hDECF80DA, 0);
    vecs[5]  = mk(0, 2'b00, 0, 32'd5,    32'h0,        32'hFFFFFF80, 0);
    vecs[6]  = mk(0, 2'b00, 1, 32'd5,    32'h0,        32'h00000080, 0);
    vecs[7]  = mk(1, 2'b01, 0, 32'd6,    32'h00008001, 32'h0,        0);
    vecs[8]  = mk(0, 2'b01, 0, 32'd6,    32'h0,        32'hFFFF8001, 0);
    vecs[9]  = mk(0, 2'b01, 1, 32'd6,    32'h0,        32'h00008001, 0);
    vecs[10] = mk(0, 2'b10, 0, 32'd4,    32'h0,        32'h800180DA, 0);
    vecs[11] = mk(0, 2'b10, 0, 32'd2,    32'h0,        32'h0,        1);
    vecs[12] = mk(1, 2'b01, 0, 32'd1,    32'h00001234, 32'h0,        1);
    vecs[13] = mk(0, 2'b10, 0, 32'd0,    32'h0,        32'hADCEAFCD, 0);
    vecs[14] = mk(0, 2'b11, 0, 32'd0,    32'h0,        32'h0,        1);
    vecs[15] = mk(0, 2'b10, 0, 32'd4096, 32'h0,        32'h0,        1);
    vecs[16] = mk(1, 2'b10, 0, 32'd4092, 32'h11223344, 32'h0,        0);
    vecs[17] = mk(0, 2'b01, 0, 32'd4094, 32'h0,        32'h00001122, 0);
    vecs[18] = mk(1, 2'b00, 0, 32'd4096, 32'h000000FF, 32'h0,        1);
    vecs[19] = mk(0, 2'b00, 0, 32'd7,    32'h0,        32'hFFFFFF80, 0);

    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'h0, bus.req_ready}, 32'h1);
    check("reset_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    check("reset_rdata", bus.rsp_rdata, 32'h0);
    check("reset_err", {31'h0, bus.rsp_err}, 32'h0);
    check("reset_busy", {31'h0, bus.busy}, 32'h0);
    check("reset_state", {30'h0, dbg_state}, {30'h0, IDLE});

    // Table-driven single requests, one at a time.
    for (int i = 0; i < 20; i++) begin
      issue(vecs[i], 1'b0, 1'b1);
      drain();
    end

    // Back-to-back loads with req_valid held high throughout.
    base_cnt = rsp_cnt;
    for (int k = 0; k < 3; k++) begin
      vec_t v;
      case (k)
        0:       v = mk(0, 2'b10, 0, 32'd0, 32'h0, 32'hADCEAFCD, 0);
        1:       v = mk(0, 2'b10, 0, 32'd4, 32'h0, 32'h800180DA, 0);
        default: v = mk(0, 2'b01, 1, 32'd6, 32'h0, 32'h00008001, 0);
      endcase
      issue(v, 1'b1, 1'b1);
      for (int j = 0; j < LAT; j++) begin
        @(negedge clk);
        check("b2b_ready_low", {31'h0, bus.req_ready}, 32'h0);
        check("b2b_busy_high", {31'h0, bus.busy}, 32'h1);
      end
    end
    bus.req_valid = 1'b0;
    drain();
    repeat (4) @(negedge clk);
    check("b2b_rsp_count", rsp_cnt - base_cnt, 32'd3);

    // Reset while a load is in WAIT: no response, data preserved.
    base_cnt = rsp_cnt;
    issue(mk(0, 2'b10, 0, 32'd0, 32'h0, 32'hADCEAFCD, 0), 1'b0, 1'b0);
    @(negedge clk);
    check("midload_state_wait", {30'h0, dbg_state}, {30'h0, WAIT});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midload_no_rsp", rsp_cnt - base_cnt, 32'd0);
    check("midload_ready", {31'h0, bus.req_ready}, 32'h1);
    check("midload_state_idle", {30'h0, dbg_state}, {30'h0, IDLE});
    issue(mk(0, 2'b10, 0, 32'd0, 32'h0, 32'hADCEAFCD, 0), 1'b0, 1'b1);
    drain();
    issue(mk(0, 2'b00, 1, 32'd4095, 32'h0, 32'h00000011, 0), 1'b0, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
